mem_arbiter: RTL and testbench

- Parametrised N-channel arbiter that shares one memory port among several valid/ready requesters, e.g. IFU instruction fetch and LSU data access.
- It is the successor to the direct per-unit memory paths.
- Adds selectable fixed-priority or round-robin arbitration, one outstanding transaction, variable memory latency and an optional response-timeout error.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter_picker.sv | 49 ++++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter.
//   state_e     : arbiter FSM states
//   PRIO_*      : arbitration mode encodings for the PRIO_MODE parameter
//   clog2_min1  : index width for a channel count, never below one bit
package mem_arbiter_pkg;

    localparam int unsigned PRIO_FIXED = 0;
    localparam int unsigned PRIO_RR    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus bundle of the arbiter.
//   slave  : arbiter view (accepts requests, drives the memory port)
//   master : environment view (requesters plus memory)
// Channel i of a flattened field occupies [i*W +: W].
interface mem_arbiter_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    localparam int unsigned GID_W  = mem_arbiter_pkg::clog2_min1(N_CH);
    localparam int unsigned MASK_W = DATA_W / 8;

    // requester side
    logic [N_CH-1:0]          req_valid;
    logic [N_CH-1:0]          req_ready;
    logic [N_CH*ADDR_W-1:0]   req_addr;
    logic [N_CH-1:0]          req_wen;
    logic [N_CH*DATA_W-1:0]   req_wdata;
    logic [N_CH*MASK_W-1:0]   req_wmask;
    logic [N_CH-1:0]          rsp_valid;
    logic [N_CH-1:0]          rsp_ready;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic [GID_W-1:0]         grant_id;

    // memory side
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_wen;
    logic [DATA_W-1:0]        mem_wdata;
    logic [MASK_W-1:0]        mem_wmask;
    logic                     mem_rsp_valid;
    logic [DATA_W-1:0]        mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/mem_arbiter_picker.sv
// Combinational winner selection.
//   req_valid : per-channel request valid
//   rr_ptr    : round-robin search start (ignored in fixed mode)
//   mode      : 0 = fixed priority (lowest index), 1 = round-robin
//   winner    : selected channel index (0 when nothing is valid)
//   any_valid : at least one request is valid
module mem_arbiter_picker
    import mem_arbiter_pkg::*;
#(
    parameter  int unsigned N_CH  = 2,
    localparam int unsigned GID_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req_valid,
    input  logic [GID_W-1:0] rr_ptr,
    input  logic             mode,
    output logic [GID_W-1:0] winner,
    output logic             any_valid
);

    // Channel visited at search offset ofs from base, wrapping at N_CH.
    function automatic logic [GID_W-1:0] rr_index(input logic [GID_W-1:0] base,
                                                  input int unsigned      ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= N_CH) begin
            sum = sum - N_CH;
        end
        return GID_W'(sum);
    endfunction

    logic [GID_W-1:0] idx;
    logic             found;

    // First valid channel in search order wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = mode ? rr_index(rr_ptr, k) : GID_W'(k);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        any_valid = found;
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing one memory port, one transaction in flight.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : requester valid/ready channels, shared response data, grant_id
//          and the single memory request/response port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PRIO_MODE = PRIO_FIXED,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int unsigned GID_W    = clog2_min1(N_CH);
    localparam int unsigned MASK_W   = DATA_W / 8;
    localparam int unsigned TIMER_W  = clog2_min1(TIMEOUT);
    localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_e              state_q, state_d;
    logic [GID_W-1:0]    grant_q, grant_d;
    logic [GID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [N_CH-1:0]     rsp_valid_q, rsp_valid_d;

    logic [GID_W-1:0]    winner;
    logic                any_valid;
    logic [N_CH-1:0]     req_ready_c;

    mem_arbiter_picker #(
        .N_CH (N_CH)
    ) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .mode      (1'(PRIO_MODE == PRIO_RR)),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Acceptance is combinational so the winner sees ready in the same cycle;
    // held low during reset so nothing appears accepted while flops are cleared.
    always_comb begin
        req_ready_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            req_ready_c[i] = rst && (state_q == IDLE) && any_valid && (GID_W'(i) == winner);
        end
    end

    // Next-state, field latches, timer and registered output decode.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        timer_d  = timer_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    addr_d  = bus.req_addr [32'(winner)*ADDR_W +: ADDR_W];
                    wen_d   = bus.req_wen  [winner];
                    wdata_d = bus.req_wdata[32'(winner)*DATA_W +: DATA_W];
                    wmask_d = bus.req_wmask[32'(winner)*MASK_W +: MASK_W];
                    grant_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response in the final timeout cycle still counts as success.
                if (bus.mem_rsp_valid) begin
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT != 0) begin
                    if (timer_q == TIMER_W'(TMO_LAST)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    state_d = IDLE;
                    if (PRIO_MODE == PRIO_RR) begin
                        rr_ptr_d = (grant_q == GID_W'(N_CH - 1)) ? '0 : grant_q + GID_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        mem_req_valid_d = (state_d == REQ);
        rsp_valid_d     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            rsp_valid_d[i] = (state_d == RESP) && (GID_W'(i) == grant_d);
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            rr_ptr_q        <= '0;
            timer_q         <= '0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
            mem_req_valid_q <= 1'b0;
            rsp_valid_q     <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            rr_ptr_q        <= rr_ptr_d;
            timer_q         <= timer_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            rdata_q         <= rdata_d;
            err_q           <= err_d;
            mem_req_valid_q <= mem_req_valid_d;
            rsp_valid_q     <= rsp_valid_d;
        end
    end

    assign bus.req_ready     = req_ready_c;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.rsp_err       = err_q;
    assign bus.grant_id      = grant_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a fixed-priority 2-channel arbiter with an 8-cycle timeout
// and a round-robin 3-channel arbiter without timeout, sharing clk and reset.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_arbiter_if #(.N_CH(2), .ADDR_W(32), .DATA_W(32)) if_a ();
    mem_arbiter_if #(.N_CH(3), .ADDR_W(32), .DATA_W(32)) if_b ();

    mem_arbiter #(
        .N_CH(2), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(PRIO_FIXED), .TIMEOUT(8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    mem_arbiter #(
        .N_CH(3), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(PRIO_RR), .TIMEOUT(0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    // Round-robin memory returns the address as read data.
    assign if_b.mem_rdata = if_b.mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives an accepted request on if_a from REQ through the response handshake.
    task automatic a_finish(input int ch, input logic [31:0] addr,
                            input logic [31:0] rdata, input string tag);
        logic [1:0] oh;
        oh = 2'b01 << ch;
        @(negedge clk);
        if_a.req_valid     = 2'b00;
        if_a.mem_req_ready = 1'b1;
        #1;
        check({tag, "_mem_valid"}, 64'(if_a.mem_req_valid), 64'd1);
        check({tag, "_mem_addr"},  64'(if_a.mem_addr), 64'(addr));
        check({tag, "_grant"},     64'(if_a.grant_id), 64'(ch));
        @(negedge clk);
        if_a.mem_req_ready = 1'b0;
        if_a.mem_rsp_valid = 1'b1;
        if_a.mem_rdata     = rdata;
        @(negedge clk);
        if_a.mem_rsp_valid = 1'b0;
        #1;
        check({tag, "_rsp_valid"}, 64'(if_a.rsp_valid), 64'(oh));
        check({tag, "_rdata"},     64'(if_a.rsp_rdata), 64'(rdata));
        check({tag, "_err"},       64'(if_a.rsp_err), 64'd0);
        if_a.rsp_ready = oh;
        @(negedge clk);
        if_a.rsp_ready = 2'b00;
        #1;
        check({tag, "_rsp_done"},  64'(if_a.rsp_valid), 64'd0);
    endtask

    // Single read on channel ch of if_a, zero-wait memory.
    task automatic a_read(input int ch, input logic [31:0] addr,
                          input logic [31:0] rdata, input string tag);
        logic [1:0] oh;
        oh = 2'b01 << ch;
        @(negedge clk);
        if_a.req_addr[ch*32 +: 32] = addr;
        if_a.req_wen[ch]           = 1'b0;
        if_a.req_valid             = oh;
        #1;
        check({tag, "_ready"}, 64'(if_a.req_ready), 64'(oh));
        a_finish(ch, addr, rdata, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int seen;
        int last;
        int exp_ch;

        rst                = 1'b0;
        if_a.req_valid     = 2'b11;
        if_a.req_addr      = '0;
        if_a.req_wen       = '0;
        if_a.req_wdata     = '0;
        if_a.req_wmask     = '0;
        if_a.rsp_ready     = '0;
        if_a.mem_req_ready = 1'b0;
        if_a.mem_rsp_valid = 1'b0;
        if_a.mem_rdata     = '0;
        if_b.req_valid     = '0;
        if_b.req_addr      = '0;
        if_b.req_wen       = '0;
        if_b.req_wdata     = '0;
        if_b.req_wmask     = '0;
        if_b.rsp_ready     = '0;
        if_b.mem_req_ready = 1'b0;
        if_b.mem_rsp_valid = 1'b0;

        // Reset state, with requests already pending on if_a.
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready",  64'(if_a.req_ready), 64'd0);
        check("rst_rsp_valid",  64'(if_a.rsp_valid), 64'd0);
        check("rst_mem_valid",  64'(if_a.mem_req_valid), 64'd0);
        check("rst_grant",      64'(if_a.grant_id), 64'd0);
        check("rst_rdata",      64'(if_a.rsp_rdata), 64'd0);
        check("rst_err",        64'(if_a.rsp_err), 64'd0);
        check("rst_b_rsp",      64'(if_b.rsp_valid), 64'd0);
        if_a.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;

        // Round-robin, all channels valid, zero-wait memory: 0,1,2,0,1,2 every 4 cycles.
        @(negedge clk);
        for (int i = 0; i < 3; i++) if_b.req_addr[i*32 +: 32] = 32'h9000_0000 + 32'(i * 16);
        if_b.req_valid     = 3'b111;
        if_b.mem_req_ready = 1'b1;
        if_b.mem_rsp_valid = 1'b1;
        if_b.rsp_ready     = 3'b111;
        seen = 0;
        last = 0;
        for (int cyc = 0; cyc < 60 && seen < 6; cyc++) begin
            @(negedge clk);
            #1;
            if (if_b.rsp_valid != 3'b000) begin
                exp_ch = seen % 3;
                check("rr_rsp_valid", 64'(if_b.rsp_valid), 64'(3'b001 << exp_ch));
                check("rr_grant",     64'(if_b.grant_id), 64'(exp_ch));
                check("rr_rdata",     64'(if_b.rsp_rdata), 64'(32'h9000_0000 + 32'(exp_ch * 16)));
                if (seen > 0) check("rr_spacing", 64'(cyc - last), 64'd4);
                last = cyc;
                seen++;
            end
        end
        check("rr_count", 64'(seen), 64'd6);
        if_b.req_valid = 3'b000;

        // Fixed priority: both valid, ch0 wins, ch1 waits for the ch0 handshake.
        @(negedge clk);
        if_a.req_addr  = {32'h8000_0100, 32'h8000_0000};
        if_a.req_wen   = 2'b00;
        if_a.req_valid = 2'b11;
        #1;
        check("fx_ready_ch0", 64'(if_a.req_ready), 64'h1);
        @(negedge clk);
        if_a.req_valid = 2'b10;
        #1;
        check("fx_mem_valid", 64'(if_a.mem_req_valid), 64'd1);
        check("fx_mem_addr",  64'(if_a.mem_addr), 64'h8000_0000);
        check("fx_grant0",    64'(if_a.grant_id), 64'd0);
        check("fx_busy_rdy",  64'(if_a.req_ready), 64'd0);
        if_a.mem_req_ready = 1'b1;
        @(negedge clk);
        if_a.mem_req_ready = 1'b0;
        if_a.mem_rsp_valid = 1'b1;
        if_a.mem_rdata     = 32'hA5A5_0001;
        @(negedge clk);
        if_a.mem_rsp_valid = 1'b0;
        #1;
        check("fx_rsp_ch0",   64'(if_a.rsp_valid), 64'h1);
        check("fx_rdata0",    64'(if_a.rsp_rdata), 64'hA5A5_0001);
        check("fx_ch1_held",  64'(if_a.req_ready), 64'd0);
        if_a.rsp_ready = 2'b10;
        @(negedge clk);
        #1;
        check("fx_wrong_rdy", 64'(if_a.rsp_valid), 64'h1);
        if_a.rsp_ready = 2'b01;
        @(negedge clk);
        if_a.rsp_ready = 2'b00;
        #1;
        check("fx_ready_ch1", 64'(if_a.req_ready), 64'h2);
        a_finish(1, 32'h8000_0100, 32'h0000_1111, "fx_ch1");

        // Write from ch1, fields held while the memory stalls for 3 cycles.
        @(negedge clk);
        if_a.req_addr[63:32]  = 32'h8000_0010;
        if_a.req_wdata[63:32] = 32'hDEAD_BEEF;
        if_a.req_wmask[7:4]   = 4'h3;
        if_a.req_wen          = 2'b10;
        if_a.req_valid        = 2'b10;
        #1;
        check("wr_ready", 64'(if_a.req_ready), 64'h2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if_a.req_valid        = 2'b00;
            if_a.req_addr[63:32]  = 32'h0BAD_0000 + 32'(k);
            if_a.req_wdata[63:32] = 32'h0;
            if_a.req_wmask[7:4]   = 4'hC;
            if_a.mem_req_ready    = (k == 3);
            #1;
            check("wr_mem_valid", 64'(if_a.mem_req_valid), 64'd1);
            check("wr_mem_wen",   64'(if_a.mem_wen), 64'd1);
            check("wr_mem_wmask", 64'(if_a.mem_wmask), 64'h3);
            check("wr_mem_addr",  64'(if_a.mem_addr), 64'h8000_0010);
            check("wr_mem_wdata", 64'(if_a.mem_wdata), 64'hDEAD_BEEF);
        end
        @(negedge clk);
        if_a.mem_req_ready = 1'b0;
        #1;
        check("wr_no_early_rsp", 64'(if_a.rsp_valid), 64'd0);
        if_a.mem_rsp_valid = 1'b1;
        @(negedge clk);
        if_a.mem_rsp_valid = 1'b0;
        #1;
        check("wr_rsp_valid", 64'(if_a.rsp_valid), 64'h2);
        check("wr_rsp_err",   64'(if_a.rsp_err), 64'd0);
        if_a.rsp_ready = 2'b10;
        @(negedge clk);
        if_a.rsp_ready = 2'b00;
        if_a.req_wen   = 2'b00;

        // Timeout: no memory response, RESP after 8 WAIT cycles with err and zero data.
        @(negedge clk);
        if_a.req_addr[31:0] = 32'h8000_0020;
        if_a.req_valid      = 2'b01;
        #1;
        check("to_ready", 64'(if_a.req_ready), 64'h1);
        @(negedge clk);
        if_a.req_valid     = 2'b00;
        if_a.mem_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if_a.mem_req_ready = 1'b0;
            #1;
            check("to_wait", 64'(if_a.rsp_valid), 64'd0);
        end
        @(negedge clk);
        #1;
        check("to_rsp_valid", 64'(if_a.rsp_valid), 64'h1);
        check("to_err",       64'(if_a.rsp_err), 64'd1);
        check("to_rdata",     64'(if_a.rsp_rdata), 64'd0);
        if_a.mem_rsp_valid = 1'b1;
        if_a.mem_rdata     = 32'h0BAD_0BAD;
        @(negedge clk);
        if_a.mem_rsp_valid = 1'b0;
        #1;
        check("to_late_rdata", 64'(if_a.rsp_rdata), 64'd0);
        check("to_late_err",   64'(if_a.rsp_err), 64'd1);
        if_a.rsp_ready = 2'b01;
        @(negedge clk);
        if_a.rsp_ready     = 2'b00;
        if_a.mem_rsp_valid = 1'b1;
        #1;
        check("to_idle_rsp", 64'(if_a.rsp_valid), 64'd0);
        @(negedge clk);
        if_a.mem_rsp_valid = 1'b0;
        a_read(0, 32'h8000_0030, 32'hCAFE_F00D, "to_next");

        // Response arriving in the last timeout cycle wins.
        @(negedge clk);
        if_a.req_addr[31:0] = 32'h8000_0040;
        if_a.req_valid      = 2'b01;
        #1;
        check("edge_ready", 64'(if_a.req_ready), 64'h1);
        @(negedge clk);
        if_a.req_valid     = 2'b00;
        if_a.mem_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if_a.mem_req_ready = 1'b0;
            if_a.mem_rsp_valid = (k == 7);
            if_a.mem_rdata     = 32'h1234_5678;
            #1;
            check("edge_wait", 64'(if_a.rsp_valid), 64'd0);
        end
        @(negedge clk);
        if_a.mem_rsp_valid = 1'b0;
        #1;
        check("edge_rsp_valid", 64'(if_a.rsp_valid), 64'h1);
        check("edge_err",       64'(if_a.rsp_err), 64'd0);
        check("edge_rdata",     64'(if_a.rsp_rdata), 64'h1234_5678);
        if_a.rsp_ready = 2'b01;
        @(negedge clk);
        if_a.rsp_ready = 2'b00;

        // Reset asserted in WAIT clears outputs at once; no response follows.
        @(negedge clk);
        if_a.req_addr[63:32] = 32'h8000_0050;
        if_a.req_valid       = 2'b10;
        #1;
        check("mrst_ready", 64'(if_a.req_ready), 64'h2);
        @(negedge clk);
        if_a.req_valid     = 2'b00;
        if_a.mem_req_ready = 1'b1;
        @(negedge clk);
        if_a.mem_req_ready = 1'b0;
        #1;
        check("mrst_pre_grant", 64'(if_a.grant_id), 64'd1);
        rst = 1'b0;
        #1;
        check("mrst_grant",     64'(if_a.grant_id), 64'd0);
        check("mrst_rsp_valid", 64'(if_a.rsp_valid), 64'd0);
        check("mrst_mem_valid", 64'(if_a.mem_req_valid), 64'd0);
        check("mrst_rdata",     64'(if_a.rsp_rdata), 64'd0);
        check("mrst_err",       64'(if_a.rsp_err), 64'd0);
        check("mrst_mem_addr",  64'(if_a.mem_addr), 64'd0);
        if_a.mem_rsp_valid = 1'b1;
        repeat (2) @(negedge clk);
        if_a.mem_rsp_valid = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("mrst_no_spur", 64'(if_a.rsp_valid), 64'd0);
        end
        a_read(0, 32'h8000_0060, 32'h600D_F00D, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
